muldiv_exec_unit: RTL and testbench
===================================

# muldiv_exec_unit

Parametrised multiply/divide functional unit for the Tomasulo core. It accepts one dispatched instruction at a time from the mul/div reservation station through a valid/ready handshake and runs a fixed-latency multiply or an iterative restoring divide/remainder. It holds the tagged result on the common data bus (CDB) port until the CDB arbiter accepts it. Compared with the earlier mul unit, it adds remainder, divide-by-zero handling, flush and back-pressure.

## Interface
Parameters:
- DATA_W, default 8: operand width.
- ROB_W, default 3: ROB index width.
- REG_W, default 4: destination register index width.
- RS_W, default 3: reservation-station index width.
- MUL_LAT, default 3: cycles spent in MUL state (legal range 1..15).

Ports:
- clk1, in, 1: the single clock; all logic on its rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- flush, in, 1: synchronous kill of any in-flight operation.
- in_valid, in, 1: a dispatch is offered.
- in_ready, out, 1: the unit can accept; high only in IDLE.
- in_func, in, 4: operation select. 4'b0010 MUL, 4'b0011 DIV, 4'b0100 REM.
- in_rs1, in, DATA_W: operand A.
- in_rs2, in, DATA_W: operand B.
- in_rob, in, ROB_W: ROB tag.
- in_rd, in, REG_W: destination register.
- in_rs_idx, in, RS_W: issuing station entry.
- busy, out, 1: the state is not IDLE.
- cdb_valid, out, 1: a result is offered on the CDB port.
- cdb_ready, in, 1: the CDB arbiter accepts the result.
- cdb_data, out, 2*DATA_W: the result.
- cdb_rob, out, ROB_W: captured ROB tag.
- cdb_rd, out, REG_W: captured destination register.
- cdb_rs_idx, out, RS_W: captured station entry, so the station can free it.
- cdb_exc, out, 1: exception flag (divide by zero or illegal func).

## Operation
- States are IDLE, MUL, DIV and DONE.
- **Accept:** an instruction is accepted on a cycle where in_valid && in_ready. The unit then captures the operands, func, rob, rd and rs_idx.
- **MUL:** the result is the full unsigned product, 2*DATA_W bits. Counter loads MUL_LAT-1 and decrements each cycle; when it reaches 0 the unit moves to DONE.
- **DIV / REM:**
  - Unsigned restoring division, one quotient bit per cycle, DATA_W cycles, then DONE.
  - DIV returns the quotient zero-extended into cdb_data.
  - REM returns the remainder zero-extended.
- **Divide by zero** (in_rs2==0 with DIV or REM):
  - The unit goes straight from IDLE to DONE with cdb_exc=1.
  - DIV returns all-ones in the low DATA_W bits.
  - REM returns the dividend.
- **Illegal func:** the unit goes IDLE to DONE with cdb_data=0 and cdb_exc=1.
- **DONE:**
  - cdb_valid=1, and all cdb_* outputs stay stable until cdb_valid && cdb_ready.
  - On that handshake the unit returns to IDLE.
  - No same-cycle re-accept: in_ready rises on the cycle after the handshake.
- **flush:**
  - Any state goes to IDLE on the next edge, and the result is discarded with no CDB handshake.
  - flush beats in_valid: no accept happens in a flush cycle.
- **Arithmetic width:** internal remainder register is DATA_W+1 bits; product register is 2*DATA_W bits. No truncation before cdb_data.

## Timing
- **Reset:** all outputs 0, except in_ready=1. The state is IDLE and the counter is 0. Reset asserted mid-operation aborts it immediately (asynchronously).
- **Latency,** for an accept in cycle T:
  - MUL: cdb_valid first high in cycle T+1+MUL_LAT.
  - DIV/REM: cdb_valid first high in T+1+DATA_W.
  - Divide by zero or illegal func: cdb_valid first high in T+1.
- **Back-pressure:** cdb_valid held indefinitely while cdb_ready=0; the unit never drops or changes a result.
- **cdb_ready while cdb_valid=0:** ignored.
- **Throughput:** one operation per (latency + 1) cycles at best.

## Structure
- Package muldiv_pkg holds:
  - the func code localparams FUNC_MUL, FUNC_DIV, FUNC_REM;
  - the state enum type muldiv_state_t.
- Sub-module muldiv_div_core: the iterative restoring divider datapath.
  - Inputs: start, dividend, divisor.
  - Outputs: quotient and remainder, registered, plus done after DATA_W cycles.
  - The FSM and the counter stay in the top level.

## Test plan
- **MUL with defaults:** 8'd200 * 8'd3 with rob=5, rd=7, rs_idx=2 -> cdb_valid in T+4, cdb_data=16'd600, tags echoed, cdb_exc=0.
- **DIV and REM:** DIV 8'd100 / 8'd7 -> cdb_data=16'd14 at T+9; REM with the same operands -> 16'd2 at T+9.
- **Divide by zero:** DIV 8'd45 / 0 -> cdb_data=16'h00FF, cdb_exc=1 at T+1; REM 8'd45 / 0 -> 16'd45, cdb_exc=1.
- **Back-pressure:** hold cdb_ready=0 for 10 cycles after cdb_valid -> outputs stable and in_ready=0 throughout. Release -> in_ready=1 the next cycle.
- **Flush and reset:** assert flush during DIV cycle 4 -> IDLE next cycle, no cdb_valid. Assert rst_n=0 mid-MUL -> all outputs 0 and in_ready=1 immediately.
- **Illegal func and parameter sweep:** func 4'b1111 -> cdb_exc=1, data 0. Rerun with DATA_W=16, MUL_LAT=1 -> 16'hFFFF*16'hFFFF = 32'hFFFE0001 at T+2.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide execution unit.
package muldiv_pkg;

  localparam logic [3:0] FUNC_MUL = 4'b0010;
  localparam logic [3:0] FUNC_DIV = 4'b0011;
  localparam logic [3:0] FUNC_REM = 4'b0100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_t;

  // Larger of two integers, used to size the shared latency counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative unsigned restoring divider: one quotient bit per step.
module muldiv_div_core #(
  parameter int DATA_W = 8
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W:0]   remainder,
  output logic              done
);

  logic [DATA_W:0]   rem_reg;
  logic [DATA_W-1:0] quo_reg;
  logic [DATA_W-1:0] dvs_reg;
  logic [DATA_W:0]   mark_reg;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;

  // Trial subtraction; a set MSB of diff means the partial remainder went negative.
  always_comb begin
    shifted = {rem_reg[DATA_W-1:0], quo_reg[DATA_W-1]};
    diff    = shifted - {1'b0, dvs_reg};
  end

  // Load on start, then shift/subtract once per step; mark_reg walks a single bit to flag completion.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      rem_reg  <= '0;
      quo_reg  <= '0;
      dvs_reg  <= '0;
      mark_reg <= '0;
    end else if (start) begin
      rem_reg  <= '0;
      quo_reg  <= dividend;
      dvs_reg  <= divisor;
      mark_reg <= {{DATA_W{1'b0}}, 1'b1};
    end else if (step) begin
      if (!diff[DATA_W]) begin
        rem_reg <= diff;
        quo_reg <= {quo_reg[DATA_W-2:0], 1'b1};
      end else begin
        rem_reg <= shifted;
        quo_reg <= {quo_reg[DATA_W-2:0], 1'b0};
      end
      mark_reg <= mark_reg << 1;
    end
  end

  assign quotient  = quo_reg;
  assign remainder = rem_reg;
  assign done      = mark_reg[DATA_W];

endmodule

// File: rtl/muldiv_exec_unit.sv
// Multiply/divide functional unit: one instruction at a time, result held on the CDB port until accepted.
module muldiv_exec_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ROB_W   = 3,
  parameter int REG_W   = 4,
  parameter int RS_W    = 3,
  parameter int MUL_LAT = 3
) (
  input  logic                clk1,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_func,
  input  logic [DATA_W-1:0]   in_rs1,
  input  logic [DATA_W-1:0]   in_rs2,
  input  logic [ROB_W-1:0]    in_rob,
  input  logic [REG_W-1:0]    in_rd,
  input  logic [RS_W-1:0]     in_rs_idx,
  output logic                busy,
  output logic                cdb_valid,
  input  logic                cdb_ready,
  output logic [2*DATA_W-1:0] cdb_data,
  output logic [ROB_W-1:0]    cdb_rob,
  output logic [REG_W-1:0]    cdb_rd,
  output logic [RS_W-1:0]     cdb_rs_idx,
  output logic                cdb_exc
);

  localparam int CNT_W = $clog2(max_int(DATA_W, MUL_LAT)) + 1;
  localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DATA_W - 1);

  muldiv_state_t state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [3:0]          func_reg;
  logic                exc_reg;
  logic [2*DATA_W-1:0] result_reg;
  logic [ROB_W-1:0]    rob_reg;
  logic [REG_W-1:0]    rd_reg;
  logic [RS_W-1:0]     rs_idx_reg;

  logic                accept;
  logic                is_mul;
  logic                is_div_rem;
  logic                div_zero;
  logic                div_start;
  logic [2*DATA_W-1:0] product;
  logic [DATA_W-1:0]   div_quo;
  logic [DATA_W:0]     div_rem;
  logic                div_done;

  assign is_mul     = (in_func == FUNC_MUL);
  assign is_div_rem = (in_func == FUNC_DIV) || (in_func == FUNC_REM);
  assign div_zero   = (in_rs2 == '0);
  // flush wins over a dispatch offered in the same cycle.
  assign accept     = in_valid && (state_reg == ST_IDLE) && !flush;
  assign div_start  = accept && is_div_rem && !div_zero;
  assign product    = {{DATA_W{1'b0}}, in_rs1} * {{DATA_W{1'b0}}, in_rs2};

  muldiv_div_core #(.DATA_W(DATA_W)) u_div_core (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .start     (div_start),
    .step      ((state_reg == ST_DIV) && !div_done),
    .dividend  (in_rs1),
    .divisor   (in_rs2),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  // State and latency counter registers.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state, counter update and handshake outputs.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    in_ready   = 1'b0;
    busy       = 1'b1;
    cdb_valid  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (accept) begin
          if (is_mul) begin
            state_next = ST_MUL;
            cnt_next   = MUL_INIT;
          end else if (is_div_rem && !div_zero) begin
            state_next = ST_DIV;
            cnt_next   = DIV_INIT;
          end else begin
            // Divide by zero and illegal funcs resolve immediately.
            state_next = ST_DONE;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt_reg == '0) state_next = ST_DONE;
        else               cnt_next   = cnt_reg - CNT_W'(1);
      end
      ST_DONE: begin
        cdb_valid = 1'b1;
        if (cdb_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (flush) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end
  end

  // Capture tags and the non-divider result (product or exception value) at accept.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      func_reg   <= '0;
      exc_reg    <= 1'b0;
      result_reg <= '0;
      rob_reg    <= '0;
      rd_reg     <= '0;
      rs_idx_reg <= '0;
    end else if (accept) begin
      func_reg   <= in_func;
      exc_reg    <= !is_mul && !(is_div_rem && !div_zero);
      rob_reg    <= in_rob;
      rd_reg     <= in_rd;
      rs_idx_reg <= in_rs_idx;
      if (is_mul)                    result_reg <= product;
      else if (in_func == FUNC_DIV)  result_reg <= {{DATA_W{1'b0}}, {DATA_W{1'b1}}};
      else if (in_func == FUNC_REM)  result_reg <= {{DATA_W{1'b0}}, in_rs1};
      else                           result_reg <= '0;
    end
  end

  // CDB payload is driven only in DONE so idle outputs read as zero.
  always_comb begin
    cdb_data   = '0;
    cdb_rob    = '0;
    cdb_rd     = '0;
    cdb_rs_idx = '0;
    cdb_exc    = 1'b0;
    if (state_reg == ST_DONE) begin
      cdb_rob    = rob_reg;
      cdb_rd     = rd_reg;
      cdb_rs_idx = rs_idx_reg;
      cdb_exc    = exc_reg;
      if (!exc_reg && (func_reg == FUNC_DIV))      cdb_data = {{DATA_W{1'b0}}, div_quo};
      else if (!exc_reg && (func_reg == FUNC_REM)) cdb_data = {{(DATA_W-1){1'b0}}, div_rem};
      else                                         cdb_data = result_reg;
    end
  end

endmodule

// File: tb/tb_muldiv_exec_unit.sv
// Directed bench for muldiv_exec_unit: default 8-bit instance plus a 16-bit, MUL_LAT=1 instance.
module tb_muldiv_exec_unit;

  logic clk1 = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk1 = ~clk1;

  // Default instance signals
  logic        flush, in_valid, in_ready, busy, cdb_valid, cdb_ready, cdb_exc;
  logic [3:0]  in_func, in_rd, cdb_rd;
  logic [7:0]  in_rs1, in_rs2;
  logic [2:0]  in_rob, in_rs_idx, cdb_rob, cdb_rs_idx;
  logic [15:0] cdb_data;

  // Wide instance signals
  logic        w_flush, w_in_valid, w_in_ready, w_busy, w_cdb_valid, w_cdb_ready, w_cdb_exc;
  logic [3:0]  w_in_func, w_in_rd, w_cdb_rd;
  logic [15:0] w_in_rs1, w_in_rs2;
  logic [2:0]  w_in_rob, w_in_rs_idx, w_cdb_rob, w_cdb_rs_idx;
  logic [31:0] w_cdb_data;

  muldiv_exec_unit dut (
    .clk1(clk1), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_func(in_func), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rob(in_rob), .in_rd(in_rd),
    .in_rs_idx(in_rs_idx), .busy(busy), .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
    .cdb_data(cdb_data), .cdb_rob(cdb_rob), .cdb_rd(cdb_rd), .cdb_rs_idx(cdb_rs_idx),
    .cdb_exc(cdb_exc)
  );

  muldiv_exec_unit #(.DATA_W(16), .MUL_LAT(1)) dut_w (
    .clk1(clk1), .rst_n(rst_n), .flush(w_flush), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_func(w_in_func), .in_rs1(w_in_rs1), .in_rs2(w_in_rs2), .in_rob(w_in_rob), .in_rd(w_in_rd),
    .in_rs_idx(w_in_rs_idx), .busy(w_busy), .cdb_valid(w_cdb_valid), .cdb_ready(w_cdb_ready),
    .cdb_data(w_cdb_data), .cdb_rob(w_cdb_rob), .cdb_rd(w_cdb_rd), .cdb_rs_idx(w_cdb_rs_idx),
    .cdb_exc(w_cdb_exc)
  );

  // Offer one dispatch at a negedge; returns at the negedge of cycle T+1.
  task automatic issue(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] rob, input logic [3:0] rd, input logic [2:0] rs);
    in_valid = 1'b1; in_func = f; in_rs1 = a; in_rs2 = b;
    in_rob = rob; in_rd = rd; in_rs_idx = rs;
    @(posedge clk1); @(negedge clk1);
    in_valid = 1'b0;
  endtask

  // Count cycles from T+1 until cdb_valid, bounded by limit.
  task automatic wait_valid(input int limit, output int lat);
    lat = 1;
    while (cdb_valid !== 1'b1 && lat < limit) begin
      @(negedge clk1); lat++;
    end
  endtask

  task automatic wait_valid_w(input int limit, output int lat);
    lat = 1;
    while (w_cdb_valid !== 1'b1 && lat < limit) begin
      @(negedge clk1); lat++;
    end
  endtask

  // Accept the held result and return at the following negedge.
  task automatic handshake();
    cdb_ready = 1'b1;
    @(posedge clk1); @(negedge clk1);
    cdb_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_cdb_valid got %b want 0", cdb_valid); end
    checks++; if ({cdb_data, cdb_rob, cdb_rd, cdb_rs_idx, cdb_exc} !== '0) begin errors++;
      $display("FAIL reset_cdb_fields got data=%h rob=%h rd=%h rs=%h exc=%b want all 0",
               cdb_data, cdb_rob, cdb_rd, cdb_rs_idx, cdb_exc); end
    $display("reset: in_ready=%b busy=%b cdb_valid=%b", in_ready, busy, cdb_valid);
  endtask

  task automatic test_mul();
    int lat;
    issue(4'b0010, 8'd200, 8'd3, 3'd5, 4'd7, 3'd2);
    wait_valid(40, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL mul_latency got %0d want 4", lat); end
    checks++; if (cdb_data !== 16'd600) begin errors++; $display("FAIL mul_data got %0d want 600", cdb_data); end
    checks++; if ({cdb_rob, cdb_rd, cdb_rs_idx} !== {3'd5, 4'd7, 3'd2}) begin errors++;
      $display("FAIL mul_tags got rob=%0d rd=%0d rs=%0d want 5 7 2", cdb_rob, cdb_rd, cdb_rs_idx); end
    checks++; if (cdb_exc !== 1'b0) begin errors++; $display("FAIL mul_exc got %b want 0", cdb_exc); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mul_done_in_ready got %b want 0", in_ready); end
    $display("mul 200*3: lat=%0d data=%0d", lat, cdb_data);
    handshake();
  endtask

  task automatic test_div();
    int lat;
    issue(4'b0011, 8'd100, 8'd7, 3'd1, 4'd3, 3'd4);
    wait_valid(40, lat);
    checks++; if (lat != 9) begin errors++; $display("FAIL div_latency got %0d want 9", lat); end
    checks++; if (cdb_data !== 16'd14) begin errors++; $display("FAIL div_data got %0d want 14", cdb_data); end
    checks++; if (cdb_exc !== 1'b0) begin errors++; $display("FAIL div_exc got %b want 0", cdb_exc); end
    $display("div 100/7: lat=%0d data=%0d", lat, cdb_data);
    handshake();
  endtask

  // cdb_ready held high throughout: ignored until the result appears.
  task automatic test_rem();
    int lat;
    cdb_ready = 1'b1;
    issue(4'b0100, 8'd100, 8'd7, 3'd6, 4'd9, 3'd1);
    wait_valid(40, lat);
    checks++; if (lat != 9) begin errors++; $display("FAIL rem_latency got %0d want 9", lat); end
    checks++; if (cdb_data !== 16'd2) begin errors++; $display("FAIL rem_data got %0d want 2", cdb_data); end
    @(posedge clk1); @(negedge clk1);
    cdb_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || cdb_valid !== 1'b0) begin errors++;
      $display("FAIL rem_after_accept got in_ready=%b cdb_valid=%b want 1 0", in_ready, cdb_valid); end
    $display("rem 100%%7: lat=%0d data=%0d", lat, cdb_data);
  endtask

  task automatic test_div_zero();
    int lat;
    issue(4'b0011, 8'd45, 8'd0, 3'd2, 4'd2, 3'd3);
    wait_valid(40, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL divz_latency got %0d want 1", lat); end
    checks++; if (cdb_data !== 16'h00FF || cdb_exc !== 1'b1) begin errors++;
      $display("FAIL divz_result got data=%h exc=%b want 00ff 1", cdb_data, cdb_exc); end
    $display("div 45/0: lat=%0d data=%h exc=%b", lat, cdb_data, cdb_exc);
    handshake();
    issue(4'b0100, 8'd45, 8'd0, 3'd2, 4'd2, 3'd3);
    wait_valid(40, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL remz_latency got %0d want 1", lat); end
    checks++; if (cdb_data !== 16'd45 || cdb_exc !== 1'b1) begin errors++;
      $display("FAIL remz_result got data=%0d exc=%b want 45 1", cdb_data, cdb_exc); end
    $display("rem 45/0: lat=%0d data=%0d exc=%b", lat, cdb_data, cdb_exc);
    handshake();
  endtask

  task automatic test_back_pressure();
    int lat;
    int bad = 0;
    issue(4'b0010, 8'd15, 8'd17, 3'd3, 4'd5, 3'd6);
    wait_valid(40, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL bp_latency got %0d want 4", lat); end
    in_valid = 1'b1; in_func = 4'b0011; in_rs1 = 8'd9; in_rs2 = 8'd2;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk1); @(negedge clk1);
      checks++;
      if (cdb_valid !== 1'b1 || cdb_data !== 16'd255 || in_ready !== 1'b0 ||
          {cdb_rob, cdb_rd, cdb_rs_idx} !== {3'd3, 4'd5, 3'd6}) begin
        errors++; bad++;
        $display("FAIL bp_hold cyc %0d got valid=%b data=%0d in_ready=%b want 1 255 0",
                 i, cdb_valid, cdb_data, in_ready);
      end
    end
    in_valid = 1'b0;
    handshake();
    checks++; if (in_ready !== 1'b1 || cdb_valid !== 1'b0) begin errors++;
      $display("FAIL bp_release got in_ready=%b cdb_valid=%b want 1 0", in_ready, cdb_valid); end
    $display("back-pressure 15*17: held 10 cycles, bad=%0d", bad);
  endtask

  task automatic test_flush();
    int seen = 0;
    issue(4'b0011, 8'd200, 8'd3, 3'd0, 4'd0, 3'd0);
    repeat (3) @(negedge clk1);
    flush = 1'b1;
    @(posedge clk1); @(negedge clk1);
    flush = 1'b0;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL flush_idle got busy=%b in_ready=%b want 0 1", busy, in_ready); end
    for (int i = 0; i < 12; i++) begin
      if (cdb_valid === 1'b1) seen++;
      @(negedge clk1);
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_result got %0d valid cycles want 0", seen); end
    flush = 1'b1;
    issue(4'b0010, 8'd2, 8'd2, 3'd0, 4'd0, 3'd0);
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_beats_valid got busy=%b want 0", busy); end
    $display("flush during div cycle 4: valid cycles seen=%0d", seen);
  endtask

  task automatic test_reset_mid();
    issue(4'b0010, 8'd9, 8'd9, 3'd1, 4'd1, 3'd1);
    @(negedge clk1);
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || cdb_valid !== 1'b0 || cdb_data !== 16'd0) begin
      errors++; $display("FAIL async_reset got in_ready=%b busy=%b valid=%b data=%h want 1 0 0 0",
                         in_ready, busy, cdb_valid, cdb_data); end
    $display("reset mid-mul: in_ready=%b busy=%b", in_ready, busy);
    @(negedge clk1);
    rst_n = 1'b1;
    @(negedge clk1);
  endtask

  task automatic test_illegal();
    int lat;
    issue(4'b1111, 8'd5, 8'd6, 3'd4, 4'd4, 3'd5);
    wait_valid(40, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL illegal_latency got %0d want 1", lat); end
    checks++; if (cdb_data !== 16'd0 || cdb_exc !== 1'b1 || cdb_rob !== 3'd4) begin errors++;
      $display("FAIL illegal_result got data=%h exc=%b rob=%0d want 0 1 4", cdb_data, cdb_exc, cdb_rob); end
    $display("illegal func 1111: lat=%0d data=%h exc=%b", lat, cdb_data, cdb_exc);
    handshake();
  endtask

  // Handshake cycle also offers the next dispatch; it must wait one cycle.
  task automatic test_back_to_back();
    int lat;
    issue(4'b0010, 8'd12, 8'd11, 3'd2, 4'd8, 3'd7);
    wait_valid(40, lat);
    checks++; if (lat != 4 || cdb_data !== 16'd132) begin errors++;
      $display("FAIL b2b_mul got lat=%0d data=%0d want 4 132", lat, cdb_data); end
    cdb_ready = 1'b1;
    in_valid = 1'b1; in_func = 4'b0011; in_rs1 = 8'd50; in_rs2 = 8'd6;
    @(posedge clk1); @(negedge clk1);
    cdb_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL b2b_no_reaccept got in_ready=%b busy=%b want 1 0", in_ready, busy); end
    @(posedge clk1); @(negedge clk1);
    in_valid = 1'b0;
    wait_valid(40, lat);
    checks++; if (lat != 9 || cdb_data !== 16'd8) begin errors++;
      $display("FAIL b2b_div got lat=%0d data=%0d want 9 8", lat, cdb_data); end
    $display("back-to-back mul then div 50/6: lat=%0d data=%0d", lat, cdb_data);
    handshake();
  endtask

  task automatic test_param_wide();
    int lat;
    w_in_valid = 1'b1; w_in_func = 4'b0010; w_in_rs1 = 16'hFFFF; w_in_rs2 = 16'hFFFF;
    @(posedge clk1); @(negedge clk1);
    w_in_valid = 1'b0;
    wait_valid_w(40, lat);
    checks++; if (lat != 2 || w_cdb_data !== 32'hFFFE0001) begin errors++;
      $display("FAIL wide_mul got lat=%0d data=%h want 2 fffe0001", lat, w_cdb_data); end
    $display("wide mul ffff*ffff: lat=%0d data=%h", lat, w_cdb_data);
    w_cdb_ready = 1'b1;
    @(posedge clk1); @(negedge clk1);
    w_cdb_ready = 1'b0;
    w_in_valid = 1'b1; w_in_func = 4'b0100; w_in_rs1 = 16'd50000; w_in_rs2 = 16'd7;
    @(posedge clk1); @(negedge clk1);
    w_in_valid = 1'b0;
    wait_valid_w(60, lat);
    checks++; if (lat != 17 || w_cdb_data !== 32'd6) begin errors++;
      $display("FAIL wide_rem got lat=%0d data=%0d want 17 6", lat, w_cdb_data); end
    $display("wide rem 50000%%7: lat=%0d data=%0d", lat, w_cdb_data);
    w_cdb_ready = 1'b1;
    @(posedge clk1); @(negedge clk1);
    w_cdb_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0; in_valid = 1'b0; cdb_ready = 1'b0; in_func = '0;
    in_rs1 = '0; in_rs2 = '0; in_rob = '0; in_rd = '0; in_rs_idx = '0;
    w_flush = 1'b0; w_in_valid = 1'b0; w_cdb_ready = 1'b0; w_in_func = '0;
    w_in_rs1 = '0; w_in_rs2 = '0; w_in_rob = '0; w_in_rd = '0; w_in_rs_idx = '0;
    repeat (2) @(negedge clk1);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk1);
    test_mul();
    test_div();
    test_rem();
    test_div_zero();
    test_back_pressure();
    test_flush();
    test_reset_mid();
    test_illegal();
    test_back_to_back();
    test_param_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
